// File: rtl/game_pkg.sv
// Shared types, constants and helpers for the note-memory game.
// Used by the round sequencer and its testbench.
package game_pkg;

  localparam int NOTE_W    = 4;
  localparam int NUM_NOTES = 8;
  localparam int MIN_ROUND = 3;
  localparam int SONG_W    = NOTE_W * NUM_NOTES;
  localparam int IDX_W     = 3;
  localparam logic [NOTE_W-1:0] DONE_LED = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY_ON,
    S_PLAY_GAP,
    S_LISTEN,
    S_PAUSE,
    S_DONE
  } state_e;

  function automatic logic [NOTE_W-1:0] note_sel(
    input logic [SONG_W-1:0] song,
    input logic [IDX_W-1:0]  idx
  );
    return song[int'(idx) * NOTE_W +: NOTE_W];
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running game-tick prescaler; one-cycle tick every TICK_DIV clocks.
// A clear restarts the period so timed states last whole periods.
module tick_prescaler #(
  parameter int TICK_DIV = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/round_sequencer.sv
// Game-flow controller: plays the first N notes of the song, checks the
// player's echo, and grows N from 3 to 8.
module round_sequencer
  import game_pkg::*;
#(
  parameter int TICK_DIV      = 5_000_000,
  parameter int NOTE_TICKS    = 2,
  parameter int GAP_TICKS     = 1,
  parameter int TIMEOUT_TICKS = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SONG_W-1:0] song_in,
  input  logic              song_load,
  input  logic              start,
  input  logic              key_valid,
  input  logic [NOTE_W-1:0] key_code,
  output logic [NOTE_W-1:0] note_out,
  output logic [NOTE_W-1:0] led_out,
  output logic              busy,
  output logic [3:0]        round_len,
  output logic              miss,
  output logic              round_pass,
  output logic              game_done,
  output logic              tick
);

  localparam int TMAX = max3(NOTE_TICKS, GAP_TICKS, TIMEOUT_TICKS);
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] T_NOTE = TW'(NOTE_TICKS - 1);
  localparam logic [TW-1:0] T_GAP  = TW'(GAP_TICKS - 1);
  localparam logic [TW-1:0] T_TOUT = TW'(TIMEOUT_TICKS - 1);
  localparam logic [3:0] LEN_MIN = 4'(MIN_ROUND);
  localparam logic [3:0] LEN_MAX = 4'(NUM_NOTES);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  play_q, play_d;
  logic [IDX_W-1:0]  key_q, key_d;
  logic [3:0]        len_q, len_d;
  logic [NOTE_W-1:0] last_q, last_d;
  logic [SONG_W-1:0] song_q, song_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              miss_q, miss_d;
  logic              pass_q, pass_d;
  logic              restart, clear;
  logic [3:0]        len_m1;
  logic [IDX_W-1:0]  last_idx;
  logic [NOTE_W-1:0] note_n, led_n;

  assign len_m1   = len_q - 4'd1;
  assign last_idx = len_m1[IDX_W-1:0];

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_presc (
    .clk  (clk),
    .reset(reset),
    .clear(clear),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    play_d  = play_q;
    key_d   = key_q;
    len_d   = len_q;
    last_d  = last_q;
    song_d  = song_q;
    tcnt_d  = tcnt_q;
    miss_d  = 1'b0;
    pass_d  = 1'b0;
    restart = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        tcnt_d = '0;
        if (song_load) song_d = song_in;
        if (start && song_q != '0) begin
          state_d = S_PLAY_ON;
          play_d  = '0;
          key_d   = '0;
          len_d   = LEN_MIN;
        end
      end
      S_PLAY_ON: begin
        if (tick) begin
          if (tcnt_q == T_NOTE) state_d = S_PLAY_GAP;
          else                  tcnt_d  = tcnt_q + 1'b1;
        end
      end
      S_PLAY_GAP: begin
        if (tick) begin
          if (tcnt_q != T_GAP) begin
            tcnt_d = tcnt_q + 1'b1;
          end else if (play_q == last_idx) begin
            state_d = S_LISTEN;
            key_d   = '0;
            last_d  = '0;
          end else begin
            state_d = S_PLAY_ON;
            play_d  = play_q + 1'b1;
          end
        end
      end
      S_LISTEN: begin
        // A key on the expiry tick wins over the timeout.
        if (key_valid) begin
          last_d = key_code;
          if (key_code != note_sel(song_q, key_q)) begin
            miss_d  = 1'b1;
            state_d = S_PAUSE;
          end else if (key_q != last_idx) begin
            key_d   = key_q + 1'b1;
            restart = 1'b1;
          end else begin
            pass_d = 1'b1;
            if (len_q == LEN_MAX) begin
              state_d = S_DONE;
            end else begin
              len_d   = len_q + 4'd1;
              state_d = S_PAUSE;
            end
          end
        end else if (tick) begin
          if (tcnt_q == T_TOUT) begin
            miss_d  = 1'b1;
            state_d = S_PAUSE;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      S_PAUSE: begin
        if (tick) begin
          if (tcnt_q == T_GAP) begin
            state_d = S_PLAY_ON;
            play_d  = '0;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    clear = restart || (state_d != state_q);
    if (clear) tcnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      play_q  <= '0;
      key_q   <= '0;
      len_q   <= LEN_MIN;
      last_q  <= '0;
      song_q  <= '0;
      tcnt_q  <= '0;
      miss_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      play_q  <= play_d;
      key_q   <= key_d;
      len_q   <= len_d;
      last_q  <= last_d;
      song_q  <= song_d;
      tcnt_q  <= tcnt_d;
      miss_q  <= miss_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    note_n = '0;
    led_n  = '0;
    unique case (state_q)
      S_PLAY_ON: begin
        note_n = note_sel(song_q, play_q);
        led_n  = note_n;
      end
      S_LISTEN: led_n = last_q;
      S_DONE:   led_n = DONE_LED;
      default:  ;
    endcase
  end

  // Outputs trail the state register by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      note_out   <= '0;
      led_out    <= '0;
      busy       <= 1'b0;
      round_len  <= LEN_MIN;
      miss       <= 1'b0;
      round_pass <= 1'b0;
      game_done  <= 1'b0;
    end else begin
      note_out   <= note_n;
      led_out    <= led_n;
      busy       <= (state_q != S_IDLE) && (state_q != S_DONE);
      round_len  <= len_q;
      miss       <= miss_q;
      round_pass <= pass_q;
      game_done  <= (state_q == S_DONE);
    end
  end

endmodule
